matrix_scan_driver: RTL and testbench

//  Panel-side consumer of the row codec: drives linesel to fetch each half-panel row pair
//  (red/red2), serialises them onto the LED panel shift chain and performs blank/latch/display.

---
 rtl/matrix_scan_driver_if.sv | 20 ++
 rtl/matrix_scan_driver.sv | 177 +++++++++++++++++
 tb/tb_matrix_scan_driver.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_scan_driver_if.sv
// Codec-side bundle: row-pair request index and returned half-panel rows.
// master = row codec, slave = scan driver.
interface matrix_scan_driver_if #(
  parameter int COLS = 32
);
  logic            linesel_en;
  logic [0:COLS-1] red;
  logic [0:COLS-1] red2;
  logic [2:0]      linesel;

  modport master (
    output linesel_en, red, red2,
    input  linesel
  );

  modport slave (
    input  linesel_en, red, red2,
    output linesel
  );
endinterface

// File: rtl/matrix_scan_driver.sv
// LED panel scan driver: fetch row pair, shift out, blank, latch, display.
// Optional MATRIX_BRIGHTNESS_EN adds a 3-bit brightness input (DISP duty).
module matrix_scan_driver #(
  parameter int COLS        = 32,
  parameter int ROWS_HALF   = 8,
  parameter int CLK_DIV     = 2,
  parameter int LAT_CYCLES  = 2,
  parameter int DISP_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
`ifdef MATRIX_BRIGHTNESS_EN
  input  logic [2:0]          brightness,
`endif
  matrix_scan_driver_if.slave codec,
  output logic                r1,
  output logic                r2,
  output logic                sclk,
  output logic                lat,
  output logic                oe_n,
  output logic [2:0]          addr,
  output logic                busy,
  output logic                frame_done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int LW = (LAT_CYCLES > 1) ? $clog2(LAT_CYCLES) : 1;
  localparam int PW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
  localparam logic [LW-1:0] LAT_MAX  = LW'(LAT_CYCLES - 1);
  localparam logic [PW-1:0] DISP_MAX = PW'(DISP_CYCLES - 1);
  localparam logic [2:0]    ROW_MAX  = 3'(ROWS_HALF - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, CAP, SHIFT, BLANK, LATCH, DISP
  } state_t;

  state_t          state;
  logic [0:COLS-1] sr1;
  logic [0:COLS-1] sr2;
  logic [DW-1:0]   div;
  logic            phase;
  logic [CW-1:0]   col;
  logic [LW-1:0]   lcnt;
  logic [PW-1:0]   dcnt;
  logic [2:0]      row;
  logic [2:0]      row_nxt;
  logic            go;
  logic            first_dark;
  logic            next_dark;

  assign go      = start && codec.linesel_en;
  assign row_nxt = (row == ROW_MAX) ? 3'd0 : row + 3'd1;

  // Serial data is the head of each shift register.
  assign r1 = sr1[0];
  assign r2 = sr2[0];

`ifdef MATRIX_BRIGHTNESS_EN
  localparam int OW = $clog2(DISP_CYCLES + 1);
  logic [OW-1:0] on_cyc;
  logic [OW-1:0] on_new;
  assign on_new = OW'(((32'(brightness) + 32'd1)
                  * 32'(DISP_CYCLES)) >> 3);
  assign first_dark = (on_new == '0);
  assign next_dark  = (OW'(dcnt) + OW'(1)) >= on_cyc;
`else
  assign first_dark = 1'b0;
  assign next_dark  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      codec.linesel <= 3'd0;
      addr          <= 3'd0;
      sr1           <= '0;
      sr2           <= '0;
      sclk          <= 1'b0;
      lat           <= 1'b0;
      oe_n          <= 1'b1;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      div           <= '0;
      phase         <= 1'b0;
      col           <= '0;
      lcnt          <= '0;
      dcnt          <= '0;
      row           <= 3'd0;
`ifdef MATRIX_BRIGHTNESS_EN
      on_cyc        <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            state         <= REQ;
            codec.linesel <= row;
            busy          <= 1'b1;
          end
        end
        REQ: state <= CAP;
        CAP: begin
          sr1   <= codec.red;
          sr2   <= codec.red2;
          sclk  <= 1'b0;
          div   <= '0;
          phase <= 1'b0;
          col   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (div != DIV_MAX) begin
            div <= div + 1'b1;
          end else begin
            div <= '0;
            if (!phase) begin
              phase <= 1'b1;
              sclk  <= 1'b1;
            end else begin
              phase <= 1'b0;
              sclk  <= 1'b0;
              sr1   <= {sr1[1:COLS-1], 1'b0};
              sr2   <= {sr2[1:COLS-1], 1'b0};
              if (col == COL_MAX) state <= BLANK;
              else col <= col + 1'b1;
            end
          end
        end
        BLANK: begin
          state <= LATCH;
          lat   <= 1'b1;
          addr  <= row;
          lcnt  <= '0;
        end
        LATCH: begin
          if (lcnt != LAT_MAX) begin
            lcnt <= lcnt + 1'b1;
          end else begin
            lat   <= 1'b0;
            oe_n  <= first_dark;
            dcnt  <= '0;
            state <= DISP;
`ifdef MATRIX_BRIGHTNESS_EN
            on_cyc <= on_new;
`endif
          end
        end
        DISP: begin
          if (dcnt != DISP_MAX) begin
            dcnt <= dcnt + 1'b1;
            oe_n <= next_dark;
          end else begin
            oe_n       <= 1'b1;
            row        <= row_nxt;
            frame_done <= (row == ROW_MAX);
            // Handshake is only re-evaluated at the row boundary.
            if (go) begin
              state         <= REQ;
              codec.linesel <= row_nxt;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed self-checking bench for matrix_scan_driver (default parameters).
// Define MATRIX_BRIGHTNESS_EN to also exercise the brightness option.
module tb_matrix_scan_driver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
`ifdef MATRIX_BRIGHTNESS_EN
  logic [2:0] brightness = 3'd7;
`endif
  logic r1, r2, sclk, lat, oe_n, busy, frame_done;
  logic [2:0] addr;

  matrix_scan_driver_if #(.COLS(32)) cif ();

  matrix_scan_driver dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
`ifdef MATRIX_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .codec      (cif),
    .r1         (r1),
    .r2         (r2),
    .sclk       (sclk),
    .lat        (lat),
    .oe_n       (oe_n),
    .addr       (addr),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  int cyc = 0;
  int edges = 0;
  int lat_hi = 0;
  int oe_low = 0;
  int busy_hi = 0;
  int fd_hi = 0;
  int viol = 0;
  int nlat = 0;
  int nfd = 0;
  logic sclk_q = 1'b0;
  logic lat_q = 1'b0;
  logic [31:0] r1_sh = '0;
  logic [31:0] r2_sh = '0;
  logic [2:0] addr_log [64];
  logic [2:0] lsel_log [64];
  int fd_cyc [16];

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    sclk_q <= sclk;
    lat_q  <= lat;
    if (sclk && !sclk_q) begin
      edges <= edges + 1;
      r1_sh <= {r1_sh[30:0], r1};
      r2_sh <= {r2_sh[30:0], r2};
    end
    if (lat) lat_hi <= lat_hi + 1;
    if (!oe_n) oe_low <= oe_low + 1;
    if (busy) busy_hi <= busy_hi + 1;
    if (frame_done) fd_hi <= fd_hi + 1;
    if (!oe_n && (lat || sclk)) viol <= viol + 1;
    if (lat && !lat_q && nlat < 64) begin
      addr_log[nlat] <= addr;
      lsel_log[nlat] <= cif.linesel;
      nlat <= nlat + 1;
    end
    if (frame_done && nfd < 16) begin
      fd_cyc[nfd] <= cyc;
      nfd <= nfd + 1;
    end
  end

  localparam logic [12:0] RST_VEC = {3'd0, 3'd0, 1'b0, 1'b0,
                                     1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  function automatic logic [12:0] out_vec();
    return {cif.linesel, addr, r1, r2, sclk, lat, oe_n, busy, frame_done};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 600 && busy; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle_timeout: busy=%b required 0", tag, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if (out_vec() !== RST_VEC) begin
      fails++;
      $display("FAIL reset_async: got %h required %h", out_vec(), RST_VEC);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (out_vec() !== RST_VEC) begin
      fails++;
      $display("FAIL reset_held: got %h required %h", out_vec(), RST_VEC);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle_no_data();
    int e0, o0, b0;
    cif.red = 32'hFFFF_FFFF;
    cif.red2 = 32'hFFFF_FFFF;
    cif.linesel_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    e0 = edges; o0 = oe_low; b0 = busy_hi;
    repeat (50) @(negedge clk);
    checks++;
    if (edges - e0 !== 0) begin
      fails++;
      $display("FAIL idle_sclk: got %0d edges required 0", edges - e0);
    end
    checks++;
    if (oe_low - o0 !== 0) begin
      fails++;
      $display("FAIL idle_oe: got %0d low cycles required 0", oe_low - o0);
    end
    checks++;
    if (busy_hi - b0 !== 0) begin
      fails++;
      $display("FAIL idle_busy: got %0d busy cycles required 0", busy_hi - b0);
    end
    start = 1'b0;
  endtask

  task automatic test_single_row();
    int e0, l0, o0, b0, n0;
    cif.red = 32'h8000_0001;
    cif.red2 = 32'h0000_0000;
    cif.linesel_en = 1'b1;
    @(negedge clk);
    e0 = edges; l0 = lat_hi; o0 = oe_low; b0 = busy_hi; n0 = nlat;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    wait_idle("row");
    checks++;
    if (edges - e0 !== 32) begin
      fails++;
      $display("FAIL row_sclk: got %0d edges required 32", edges - e0);
    end
    checks++;
    if (r1_sh !== 32'h8000_0001) begin
      fails++;
      $display("FAIL row_r1: got %h required 80000001", r1_sh);
    end
    checks++;
    if (r2_sh !== 32'h0) begin
      fails++;
      $display("FAIL row_r2: got %h required 00000000", r2_sh);
    end
    checks++;
    if (lat_hi - l0 !== 2) begin
      fails++;
      $display("FAIL row_lat: got %0d cycles required 2", lat_hi - l0);
    end
    checks++;
    if (oe_low - o0 !== 256) begin
      fails++;
      $display("FAIL row_oe: got %0d cycles required 256", oe_low - o0);
    end
    checks++;
    if (busy_hi - b0 !== 389) begin
      fails++;
      $display("FAIL row_period: got %0d cycles required 389", busy_hi - b0);
    end
    checks++;
    if (nlat - n0 !== 1 || addr_log[n0] !== 3'd0) begin
      fails++;
      $display("FAIL row_addr: got %0d latches addr %0d required 1 addr 0",
               nlat - n0, addr_log[n0]);
    end
  endtask

  task automatic test_reset_mid_shift();
    cif.linesel_en = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 500 && !sclk; i++) @(negedge clk);
    checks++;
    if (sclk !== 1'b1) begin
      fails++;
      $display("FAIL midshift_reach: sclk=%b required 1", sclk);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_vec() !== RST_VEC) begin
      fails++;
      $display("FAIL reset_midshift: got %h required %h", out_vec(), RST_VEC);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame();
    int n0, f0, h0;
    cif.red = 32'hC000_0001;
    cif.red2 = 32'h0000_00F5;
    cif.linesel_en = 1'b1;
    @(negedge clk);
    n0 = nlat; f0 = nfd; h0 = fd_hi;
    start = 1'b1;
    for (int i = 0; i < 7000 && nfd < f0 + 2; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (nfd - f0 !== 2) begin
      fails++;
      $display("FAIL frame_pulses: got %0d required 2", nfd - f0);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (addr_log[n0 + k] !== 3'(k) || lsel_log[n0 + k] !== 3'(k)) begin
        fails++;
        $display("FAIL frame_seq%0d: addr %0d linesel %0d required %0d",
                 k, addr_log[n0 + k], lsel_log[n0 + k], k);
      end
    end
    checks++;
    if (addr_log[n0 + 8] !== 3'd0 || lsel_log[n0 + 8] !== 3'd0) begin
      fails++;
      $display("FAIL frame_wrap: addr %0d linesel %0d required 0",
               addr_log[n0 + 8], lsel_log[n0 + 8]);
    end
    checks++;
    if (fd_cyc[f0 + 1] - fd_cyc[f0] !== 3112) begin
      fails++;
      $display("FAIL frame_period: got %0d required 3112",
               fd_cyc[f0 + 1] - fd_cyc[f0]);
    end
    checks++;
    if (fd_hi - h0 !== 2) begin
      fails++;
      $display("FAIL frame_pulse_width: got %0d cycles required 2", fd_hi - h0);
    end
    checks++;
    if (r1_sh !== 32'hC000_0001 || r2_sh !== 32'h0000_00F5) begin
      fails++;
      $display("FAIL frame_bits: r1 %h r2 %h required c0000001 000000f5",
               r1_sh, r2_sh);
    end
    start = 1'b0;
    wait_idle("frame");
  endtask

  task automatic test_drop_resume();
    int e0, o0;
    do_reset();
    cif.red = 32'h0F00_0003;
    cif.red2 = 32'hA000_0005;
    cif.linesel_en = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 2000 && !(cif.linesel == 3'd3 && sclk); i++)
      @(negedge clk);
    checks++;
    if (cif.linesel !== 3'd3 || sclk !== 1'b1) begin
      fails++;
      $display("FAIL drop_reach: linesel %0d sclk %b required 3 1",
               cif.linesel, sclk);
    end
    cif.linesel_en = 1'b0;
    wait_idle("drop");
    checks++;
    if (addr_log[nlat - 1] !== 3'd3) begin
      fails++;
      $display("FAIL drop_row3: last addr %0d required 3", addr_log[nlat - 1]);
    end
    checks++;
    if (r1_sh !== 32'h0F00_0003 || r2_sh !== 32'hA000_0005) begin
      fails++;
      $display("FAIL drop_bits: r1 %h r2 %h required 0f000003 a0000005",
               r1_sh, r2_sh);
    end
    e0 = edges; o0 = oe_low;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || oe_n !== 1'b1 || edges != e0 || oe_low != o0) begin
      fails++;
      $display("FAIL drop_idle: busy %b oe_n %b required 0 1", busy, oe_n);
    end
    cif.linesel_en = 1'b1;
    for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || cif.linesel !== 3'd4) begin
      fails++;
      $display("FAIL resume_row4: busy %b linesel %0d required 1 4",
               busy, cif.linesel);
    end
    start = 1'b0;
    wait_idle("resume");
    checks++;
    if (addr_log[nlat - 1] !== 3'd4) begin
      fails++;
      $display("FAIL resume_addr: got %0d required 4", addr_log[nlat - 1]);
    end
  endtask

`ifdef MATRIX_BRIGHTNESS_EN
  task automatic test_brightness();
    int o0, b0;
    brightness = 3'd3;
    cif.linesel_en = 1'b1;
    @(negedge clk);
    o0 = oe_low; b0 = busy_hi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    wait_idle("bright");
    checks++;
    if (oe_low - o0 !== 128) begin
      fails++;
      $display("FAIL bright_oe: got %0d cycles required 128", oe_low - o0);
    end
    checks++;
    if (busy_hi - b0 !== 389) begin
      fails++;
      $display("FAIL bright_period: got %0d cycles required 389", busy_hi - b0);
    end
    brightness = 3'd7;
  endtask
`endif

  task automatic test_invariants();
    checks++;
    if (viol !== 0) begin
      fails++;
      $display("FAIL oe_overlap: got %0d cycles required 0", viol);
    end
  endtask

  initial begin
    cif.linesel_en = 1'b0;
    cif.red = '0;
    cif.red2 = '0;
    test_reset();
    test_idle_no_data();
    test_single_row();
    test_reset_mid_shift();
    test_frame();
    test_drop_resume();
`ifdef MATRIX_BRIGHTNESS_EN
    test_brightness();
`endif
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
